jk_mod_counter: RTL and testbench
=================================

Name: jk_mod_counter

Overview:
- Synchronous modulo-N up/down counter whose state register is a bank of JK-type storage bits.
- Uses the team's JK encoding: J=1,K=1 toggles; J=1,K=0 clears to 0; J=0,K=1 sets to 1; J=0,K=0 holds.
- Contains the excitation stage that computes each bit's J/K from the current state and the control inputs. Drives the per-bit J/K pairs and the count value to downstream logic.
- Sits directly upstream of the JK storage cells and is the counting front-end of the sequential datapath.

Parameters:
- WIDTH, 4, counter bit width.
- MODULUS, 10, count range 0..MODULUS-1. Legal range 2 <= MODULUS <= 2**WIDTH; an illegal value is an elaboration error.

Ports:
- CLK  input  1  clock, rising-edge active.
- RESET  input  1  asynchronous reset, active-high.
- EN  input  1  count enable.
- UP  input  1  direction: 1 = increment, 0 = decrement.
- LOAD  input  1  synchronous parallel load, priority over EN.
- LOAD_VAL  input  WIDTH  value to load.
- Q  output  WIDTH  current count (registered).
- J_BUS  output  WIDTH  per-bit J excitation for the next edge (combinational).
- K_BUS  output  WIDTH  per-bit K excitation for the next edge (combinational).
- TC  output  1  terminal count (combinational).
- OVF  output  1  sticky wrap flag (registered).

Behaviour:
- Reset: while RESET=1, Q=0 and OVF=0 immediately, regardless of CLK. Count resumes on the first rising CLK after RESET falls.
- Next value N, computed each cycle:
  - LOAD=1: N = LOAD_VAL if LOAD_VAL < MODULUS, otherwise N = 0.
  - LOAD=0, EN=1, UP=1: N = Q+1; Q = MODULUS-1 wraps to 0.
  - LOAD=0, EN=1, UP=0: N = Q-1; Q = 0 wraps to MODULUS-1.
  - LOAD=0, EN=0: N = Q.
- Excitation, fixed encoding per bit i:
  - J_BUS[i] = K_BUS[i] = Q[i] XOR N[i], i.e. a changing bit toggles and an unchanged bit holds.
  - The clear-only and set-only encodings are never produced.
  - Each storage bit updates on the rising CLK edge per the team's JK rules, so Q equals N one cycle later (latency 1).
- TC = EN & ~LOAD & ((UP & Q==MODULUS-1) | (~UP & Q==0)).
- OVF:
  - Set on the edge where TC=1.
  - Cleared on any edge with LOAD=1; LOAD wins over a simultaneous TC.
  - Otherwise holds.
- Simultaneous LOAD and EN: LOAD wins; UP is ignored.
- Direction change mid-count: takes effect on the next edge with no bubble.
- Reset mid-operation: reset overrides everything, including a LOAD in the same cycle.
- Q is never outside 0..MODULUS-1.

Optional Feature:
- Macro: JK_MOD_COUNTER_SAT_EN.
- Defined (saturating mode):
  - Counting up at Q=MODULUS-1 holds at MODULUS-1; counting down at Q=0 holds at 0. J_BUS and K_BUS are 0 in that cycle.
  - TC and OVF behave as above, so OVF flags the attempted overflow.
- Undefined: wrap-around as described in Behaviour.

Test Plan (WIDTH=4, MODULUS=10):
- Assert RESET mid-count at Q=7, asynchronously between edges -> Q=0 and OVF=0 before the next CLK edge; Q stays 0 while RESET is held.
- EN=1, UP=1 from 0 for 12 edges -> Q=1..9,0,1,2. TC=1 only while Q=9. OVF rises after the 9->0 edge.
- At Q=9: J_BUS=4'b1001, K_BUS=4'b1001 (9->0). At Q=3 counting up: J_BUS=K_BUS=4'b0111 (3->4).
- EN=1, UP=0 from Q=0 -> Q=9, with TC=1 in the cycle before the edge. With JK_MOD_COUNTER_SAT_EN defined -> Q stays 0, J_BUS=K_BUS=0, OVF=1.
- LOAD=1, LOAD_VAL=6 with EN=1, UP=1 in the same cycle -> Q=6 and OVF cleared. LOAD_VAL=12 -> Q=0.
- EN=0 for 5 edges at Q=4 with UP toggling -> Q stays 4, J_BUS=K_BUS=0, TC=0.

Source files
------------

// File: rtl/jk_mod_counter.sv
// jk_mod_counter: modulo-MODULUS up/down counter built on a bank of JK storage
// bits. The excitation stage computes the next count N and drives each bit
// with J=K=Q^N, so changed bits toggle and unchanged bits hold.
// Optional feature: define JK_MOD_COUNTER_SAT_EN to saturate at the range
// ends instead of wrapping.

// One JK storage bit: 11 toggles, 10 clears, 01 sets, 00 holds.
module jk_mod_counter_cell (
    input  logic CLK,
    input  logic RESET,
    input  logic j_i,
    input  logic k_i,
    output logic q_o
);
    logic q_q;

    // JK update on the rising edge; reset forces the bit low immediately
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            q_q <= 1'b0;
        end else begin
            case ({j_i, k_i})
                2'b11:   q_q <= ~q_q;
                2'b10:   q_q <= 1'b0;
                2'b01:   q_q <= 1'b1;
                default: q_q <= q_q;
            endcase
        end
    end

    assign q_o = q_q;
endmodule

module jk_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic             UP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] J_BUS,
    output logic [WIDTH-1:0] K_BUS,
    output logic             TC,
    output logic             OVF
);
    // Reject a modulus that cannot be represented or counts nothing
    if (WIDTH < 1 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_param
        $error("jk_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

    logic [WIDTH-1:0] q_bits;
    logic [WIDTH-1:0] n_d;
    logic [WIDTH-1:0] exc;
    logic             at_max;
    logic             at_zero;
    logic             load_ok;
    logic             tc_d;
    logic             ovf_q;
    logic             ovf_d;

    assign at_max  = (q_bits == MAX_V);
    assign at_zero = (q_bits == '0);
    // Out-of-range load values collapse to 0 so Q never leaves 0..MODULUS-1
    assign load_ok = ({1'b0, LOAD_VAL} < MOD_EXT);

    // Next count: load beats enable; direction picks increment or decrement
    always_comb begin
        n_d = q_bits;
        if (LOAD) begin
            n_d = load_ok ? LOAD_VAL : '0;
        end else if (EN) begin
            if (UP) begin
`ifdef JK_MOD_COUNTER_SAT_EN
                n_d = at_max ? q_bits : q_bits + WIDTH'(1);
`else
                n_d = at_max ? '0 : q_bits + WIDTH'(1);
`endif
            end else begin
`ifdef JK_MOD_COUNTER_SAT_EN
                n_d = at_zero ? q_bits : q_bits - WIDTH'(1);
`else
                n_d = at_zero ? MAX_V : q_bits - WIDTH'(1);
`endif
            end
        end
    end

    // Only the toggle/hold encodings are used: J=K=1 where a bit must change
    assign exc   = q_bits ^ n_d;
    assign J_BUS = exc;
    assign K_BUS = exc;

    assign tc_d = EN & ~LOAD & ((UP & at_max) | (~UP & at_zero));
    assign TC   = tc_d;

    // Sticky overflow: load clears (and wins over TC), TC sets, else hold
    always_comb begin
        ovf_d = ovf_q;
        if (LOAD) begin
            ovf_d = 1'b0;
        end else if (tc_d) begin
            ovf_d = 1'b1;
        end
    end

    // Overflow flag register with asynchronous clear
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_mod_counter_cell u_cell (
            .CLK   (CLK),
            .RESET (RESET),
            .j_i   (J_BUS[i]),
            .k_i   (K_BUS[i]),
            .q_o   (q_bits[i])
        );
    end

    assign Q   = q_bits;
    assign OVF = ovf_q;
endmodule

// File: tb/tb_jk_mod_counter.sv
// Scoreboard bench for jk_mod_counter (WIDTH=4, MODULUS=10). Stimulus pushes
// expected excitation/TC and expected post-edge Q/OVF into queues; two monitor
// processes pop and compare independently.
module tb_jk_mod_counter;
    localparam int W = 4;
    localparam int M = 10;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         EN = 1'b0;
    logic         UP = 1'b0;
    logic         LOAD = 1'b0;
    logic [W-1:0] LOAD_VAL = '0;
    logic [W-1:0] Q;
    logic [W-1:0] J_BUS;
    logic [W-1:0] K_BUS;
    logic         TC;
    logic         OVF;

    jk_mod_counter #(.WIDTH(W), .MODULUS(M)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .EN       (EN),
        .UP       (UP),
        .LOAD     (LOAD),
        .LOAD_VAL (LOAD_VAL),
        .Q        (Q),
        .J_BUS    (J_BUS),
        .K_BUS    (K_BUS),
        .TC       (TC),
        .OVF      (OVF)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [W-1:0] exc; logic tc; } comb_exp_t;
    typedef struct { logic [W-1:0] q; logic ovf; } seq_exp_t;

    comb_exp_t comb_q[$];
    seq_exp_t  seq_q[$];

    int checks = 0;
    int failures = 0;
    int m_q = 0;       // reference count
    bit m_ovf = 1'b0;  // reference sticky flag
    bit done = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: next count from the rules using plain integer arithmetic
    function automatic int next_val(input bit ld, input int lv, input bit en, input bit up, input int q);
        if (ld) return (lv < M) ? lv : 0;
        if (!en) return q;
`ifdef JK_MOD_COUNTER_SAT_EN
        if (up) return (q == M-1) ? q : q + 1;
        return (q == 0) ? q : q - 1;
`else
        if (up) return (q + 1) % M;
        return (q + M - 1) % M;
`endif
    endfunction

    // One clock cycle of stimulus; rst asserts RESET mid-cycle through the next edge
    task automatic cycle(input bit ld, input int lv, input bit en, input bit up, input bit rst);
        int n;
        bit tc;
        comb_exp_t ce;
        seq_exp_t se;
        @(negedge CLK);
        RESET = 1'b0;
        LOAD = ld; LOAD_VAL = W'(lv); EN = en; UP = up;
        n = next_val(ld, lv, en, up, m_q);
        tc = en && !ld && ((up && m_q == M-1) || (!up && m_q == 0));
        ce.exc = W'(m_q ^ n);
        ce.tc = tc;
        comb_q.push_back(ce);
        if (rst) begin
            #3 RESET = 1'b1;
            #1;
            chk("async_reset_q", int'(Q), 0);
            chk("async_reset_ovf", int'(OVF), 0);
            m_q = 0;
            m_ovf = 1'b0;
        end else begin
            if (ld) m_ovf = 1'b0;
            else if (tc) m_ovf = 1'b1;
            m_q = n;
        end
        se.q = W'(m_q);
        se.ovf = m_ovf;
        seq_q.push_back(se);
    endtask

    // Combinational monitor: excitation and TC mid-cycle, after inputs settle
    initial begin
        comb_exp_t e;
        while (!done) begin
            @(negedge CLK);
            #2;
            if (comb_q.size() > 0) begin
                e = comb_q.pop_front();
                chk("j_bus", int'(J_BUS), int'(e.exc));
                chk("k_bus", int'(K_BUS), int'(e.exc));
                chk("tc", int'(TC), int'(e.tc));
            end
        end
    end

    // Registered monitor: Q and OVF just after each rising edge
    initial begin
        seq_exp_t e;
        while (!done) begin
            @(posedge CLK);
            #1;
            if (seq_q.size() > 0) begin
                e = seq_q.pop_front();
                chk("q", int'(Q), int'(e.q));
                chk("ovf", int'(OVF), int'(e.ovf));
            end
        end
    end

    initial begin
        #2;
        chk("reset_q", int'(Q), 0);
        chk("reset_ovf", int'(OVF), 0);
        // count up through the wrap
        for (int i = 0; i < 12; i++) cycle(0, 0, 1, 1, 0);
        // load 0 then decrement through 0
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);
        // load with enable in the same cycle, then out-of-range load
        cycle(1, 6, 1, 1, 0);
        cycle(1, 12, 1, 0, 0);
        // hold at 4 with direction toggling
        cycle(1, 4, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, i % 2, 0);
        // reset mid-count at 7, with a load in the same cycle
        cycle(1, 7, 0, 0, 0);
        cycle(1, 5, 1, 1, 1);
        cycle(0, 0, 1, 1, 0);
        // randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 9) == 0), int'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 49) == 0));
        end
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        if (comb_q.size() != 0 || seq_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain comb_left=%0d seq_left=%0d expected=0", comb_q.size(), seq_q.size());
        end
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
